// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and opcode legality shared by the alu_pipe slice
package alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOR  = 4'd5,
    OP_SLT  = 4'd6,
    OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SRA  = 4'd9,
    OP_SLTU = 4'd10,
    OP_MUL  = 4'd11,
    OP_ILL  = 4'd12
  } alu_op_e;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} alu_state_e;
  function automatic logic alu_is_legal(input logic [3:0] op);
    return op < OP_ILL;
  endfunction
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: shift-add multiplier, one partial product per cycle over WIDTH cycles
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);
  logic               run;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  assign product = acc + (mplier[0] ? mcand : '0);
  assign done = run && cnt == CW'(WIDTH - 1);
  // capture operands on start, then add one shifted partial product per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run    <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
    end else if (start) begin
      run    <= 1'b1;
      cnt    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      acc    <= '0;
      mplier <= b;
    end else if (run) begin
      run    <= !done;
      cnt    <= cnt + 1'b1;
      mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
      acc    <= product;
      mplier <= mplier >> 1;
    end
  end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshakes and flags; ALU_PIPE_MUL_EN adds the iterative MUL
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_err
);
  localparam int SHW = $clog2(WIDTH);
  logic             accept;
  logic             load;
  logic             legal;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             ovf;
  logic [WIDTH-1:0] ld_res;
  logic             ld_carry;
  logic             ld_ovf;
  logic             ld_err;
  assign sh = in_b[SHW-1:0];
  assign accept = in_valid && in_ready;
  // single-cycle datapath on the presented operands; MUL and illegal ops yield zero here
  always_comb begin
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (in_op)
      OP_ADD: begin
        {carry, res} = {1'b0, in_a} + {1'b0, in_b};
        ovf = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (res[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        {carry, res} = {1'b0, in_a} - {1'b0, in_b};
        ovf = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (res[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_AND:  res = in_a & in_b;
      OP_OR:   res = in_a | in_b;
      OP_XOR:  res = in_a ^ in_b;
      OP_NOR:  res = ~(in_a | in_b);
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(in_a) < $signed(in_b)};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, in_a < in_b};
      OP_SLL:  res = in_a << sh;
      OP_SRL:  res = in_a >> sh;
      OP_SRA:  res = $signed(in_a) >>> sh;
      default: res = '0;
    endcase
  end
`ifdef ALU_PIPE_MUL_EN
  alu_state_e         state;
  alu_state_e         state_nxt;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] product;
  assign legal = alu_is_legal(in_op);
  assign mul_start = accept && in_op == OP_MUL;
  assign in_ready = rst_n && state == IDLE && (!out_valid || out_ready);
  assign load = (accept && !mul_start) || mul_done;
  assign ld_res = mul_done ? product[WIDTH-1:0] : res;
  assign ld_carry = mul_done ? |product[2*WIDTH-1:WIDTH] : carry;
  assign ld_ovf = mul_done ? 1'b0 : ovf;
  assign ld_err = mul_done ? 1'b0 : !legal;
  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  // stay BUSY from MUL acceptance until the multiplier finishes its last iteration
  always_comb begin
    state_nxt = state == IDLE ? (mul_start ? BUSY : IDLE) : (mul_done ? IDLE : BUSY);
  end
  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (in_a),
    .b       (in_b),
    .done    (mul_done),
    .product (product)
  );
`else
  assign legal = alu_is_legal(in_op) && in_op != OP_MUL;
  assign in_ready = rst_n && (!out_valid || out_ready);
  assign load = accept;
  assign ld_res = res;
  assign ld_carry = carry;
  assign ld_ovf = ovf;
  assign ld_err = !legal;
`endif
  // output register: load a new result, otherwise hold until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_neg    <= 1'b0;
      out_carry  <= 1'b0;
      out_ovf    <= 1'b0;
      out_err    <= 1'b0;
    end else begin
      if (load) begin
        out_result <= ld_res;
        out_zero   <= ld_res == '0;
        out_neg    <= ld_res[WIDTH-1];
        out_carry  <= ld_carry;
        out_ovf    <= ld_ovf;
        out_err    <= ld_err;
      end
      out_valid <= load || (out_valid && !out_ready);
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed self-checking bench for alu_pipe at WIDTH=8
module tb_alu_pipe;
  import alu_pkg::*;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic [3:0] in_op = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_result;
  logic       out_zero, out_neg, out_carry, out_ovf, out_err;
  logic [4:0] flags;
  int         errors = 0;
  int         checks = 0;
  int         takes = 0;
  int         t0;
  logic       bad;
  assign flags = {out_err, out_ovf, out_carry, out_neg, out_zero};
  alu_pipe #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .out_carry  (out_carry),
    .out_ovf    (out_ovf),
    .out_err    (out_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (out_valid && out_ready) takes++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int n;
    in_op = op;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    n = 0;
    #0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk("issue_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    in_a = 8'hA5;
    in_b = 8'h5A;
  endtask
  task automatic expect_res(input string tag, input logic [7:0] r, input logic [4:0] f);
    chk({tag, "_valid"}, out_valid, 1);
    chk(tag, out_result, r);
    chk({tag, "_flags"}, flags, f);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    #2 rst_n = 1'b0;
    step();
    step();
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_result", out_result, 0);
    chk("rst_flags", flags, 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", in_ready, 1);
    issue(OP_ADD, 8'hFF, 8'h01);
    expect_res("add_ff_01", 8'h00, 5'b00101);
    step();
    chk("add_one_cycle", out_valid, 0);
    issue(OP_SUB, 8'h80, 8'h01);
    expect_res("sub_80_01", 8'h7F, 5'b01000);
    issue(OP_SUB, 8'h01, 8'h02);
    expect_res("sub_01_02", 8'hFF, 5'b00110);
    issue(OP_SRA, 8'h80, 8'h03);
    expect_res("sra", 8'hF0, 5'b00010);
    issue(OP_SLL, 8'h81, 8'h09);
    expect_res("sll", 8'h02, 5'b00000);
    issue(OP_SRL, 8'h80, 8'h07);
    expect_res("srl", 8'h01, 5'b00000);
    issue(OP_SLT, 8'hFF, 8'h01);
    expect_res("slt", 8'h01, 5'b00000);
    issue(OP_SLTU, 8'hFF, 8'h01);
    expect_res("sltu", 8'h00, 5'b00001);
    issue(OP_ADD, 8'h7F, 8'h01);
    expect_res("add_ovf", 8'h80, 5'b01010);
    issue(OP_OR, 8'h81, 8'h02);
    expect_res("or", 8'h83, 5'b00010);
    issue(OP_NOR, 8'h0F, 8'hF0);
    expect_res("nor", 8'h00, 5'b00001);
    issue(OP_XOR, 8'hF0, 8'hFF);
    expect_res("xor", 8'h0F, 5'b00000);
    issue(OP_AND, 8'hF0, 8'h3C);
    expect_res("and", 8'h30, 5'b00000);
    issue(4'hE, 8'h55, 8'h33);
    expect_res("illegal_e", 8'h00, 5'b10001);
`ifndef ALU_PIPE_MUL_EN
    issue(OP_MUL, 8'h0F, 8'h03);
    expect_res("mul_disabled", 8'h00, 5'b10001);
`endif
    step();
    chk("drained", out_valid, 0);
    out_ready = 1'b0;
    t0 = takes;
    in_op = OP_ADD;
    in_a = 8'h10;
    in_b = 8'h20;
    in_valid = 1'b1;
    #0;
    chk("bp_ready0", in_ready, 1);
    step();
    in_a = 8'h01;
    in_b = 8'h02;
    expect_res("bp_first", 8'h30, 5'b00000);
    chk("bp_blocked", in_ready, 0);
    step();
    chk("bp_hold1", out_result, 8'h30);
    chk("bp_blocked1", in_ready, 0);
    step();
    chk("bp_hold2", out_result, 8'h30);
    chk("bp_valid2", out_valid, 1);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    expect_res("bp_second", 8'h03, 5'b00000);
    step();
    chk("bp_empty", out_valid, 0);
    chk("bp_takes", takes - t0, 2);
`ifdef ALU_PIPE_MUL_EN
    issue(OP_MUL, 8'h10, 8'h10);
    for (int i = 0; i < 8; i++) begin
      chk("mul1_busy", {in_ready, out_valid}, 0);
      step();
    end
    expect_res("mul_10_10", 8'h00, 5'b00101);
    issue(OP_MUL, 8'h0F, 8'h03);
    for (int i = 0; i < 8; i++) begin
      chk("mul2_busy", {in_ready, out_valid}, 0);
      step();
    end
    expect_res("mul_0f_03", 8'h2D, 5'b00000);
    step();
    issue(OP_MUL, 8'h0F, 8'h03);
    step();
    step();
    step();
`else
    out_ready = 1'b0;
    issue(OP_ADD, 8'h40, 8'h01);
    expect_res("pre_rst_hold", 8'h41, 5'b00000);
    step();
`endif
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_ready", in_ready, 0);
    chk("midrst_result", out_result, 0);
    chk("midrst_flags", flags, 0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    issue(OP_ADD, 8'h02, 8'h03);
    expect_res("post_rst_add", 8'h05, 5'b00000);
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid) bad = 1'b1;
    end
    chk("no_residual", bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
